// File: rtl/zint_sched.sv
// Interrupt source scheduler for the Z80 INT pulse generator: latches per-source
// requests, picks the highest-priority enabled one, strobes the INT generator and retires on INTACK.
module zint_sched #(
  parameter int NSRC    = 4,
  parameter int TIMEOUT = 640,
  parameter int HOLDOFF = 300,
  parameter int CNT_W   = 10
) (
  input  logic            fclk,
  input  logic            rst,
  input  logic [NSRC-1:0] req,
  input  logic            intack,
  input  logic            cfg_wr,
  input  logic [1:0]      cfg_addr,
  input  logic [7:0]      cfg_din,
  output logic            int_start,
  output logic [7:0]      vector,
  output logic [NSRC-1:0] served,
  output logic [NSRC-1:0] pending,
  output logic            busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HO_LOAD = CNT_W'(HOLDOFF - 1);

  // Handshake: req/intack/cfg_wr are single-cycle strobes sampled on the rising
  // edge; int_start and served are registered one-cycle strobes with no back-pressure.

  logic [1:0]       state;
  logic [CNT_W-1:0] timer;
  logic [NSRC-1:0]  pend;
  logic [NSRC-1:0]  en;
  logic [4:0]       vbase;
  logic [1:0]       sel;

  logic [NSRC-1:0]  elig;
  logic [1:0]       pick;
  logic [NSRC-1:0]  sel_oh;
  logic             retire;
  logic [NSRC-1:0]  pend_set;
  logic [NSRC-1:0]  pend_clr;
  logic [NSRC-1:0]  pend_nxt;

  // Lowest eligible index wins; scanning downward leaves the smallest one in pick.
  always_comb begin
    elig = pend & en;
    pick = 2'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) pick = 2'(i);
    end
  end

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NSRC; i++) begin
      sel_oh[i] = (sel == 2'(i));
    end
  end

  assign retire = (state == S_WAIT) && intack;

  // Set sources beat clear sources so a request coinciding with its own retire is not lost.
  always_comb begin
    pend_set = req;
    pend_clr = '0;
    if (cfg_wr && cfg_addr == 2'd3) pend_set = pend_set | cfg_din[NSRC-1:0];
    if (cfg_wr && cfg_addr == 2'd2) pend_clr = cfg_din[NSRC-1:0];
    if (retire) pend_clr = pend_clr | sel_oh;
    pend_nxt = (pend & ~pend_clr) | pend_set;
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      pend      <= '0;
      en        <= '0;
      vbase     <= 5'b11111;
      sel       <= 2'd0;
      int_start <= 1'b0;
      served    <= '0;
    end else begin
      int_start <= 1'b0;
      served    <= '0;
      pend      <= pend_nxt;
      if (cfg_wr && cfg_addr == 2'd0) en <= cfg_din[NSRC-1:0];
      if (cfg_wr && cfg_addr == 2'd1) vbase <= cfg_din[7:3];

      case (state)
        S_IDLE: begin
          if (elig != '0) begin
            sel       <= pick;
            int_start <= 1'b1;
            timer     <= TO_LOAD;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (intack) begin
            served <= sel_oh;
            timer  <= HO_LOAD;
            state  <= S_HOLD;
          end else if (timer == '0) begin
            // Abandoned: pend is left intact so the source is offered again after HOLD.
            timer <= HO_LOAD;
            state <= S_HOLD;
          end else begin
            timer <= timer - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (timer == '0) begin
            state <= S_IDLE;
          end else begin
            timer <= timer - CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  assign vector  = {vbase, sel, 1'b0};
  assign pending = pend;
  assign busy    = (state != S_IDLE);

endmodule

// File: doc/zint_sched.md
# zint_sched

Interrupt source scheduler feeding the Z80 INT pulse generator. Collects single-cycle interrupt requests from up to four sources, holds them pending, selects the highest-priority enabled one and issues a one-cycle `int_start` strobe to the INT generator. It supplies the matching IM2 vector byte and retires the source on INTACK. Unacknowledged interrupts are retried after a timeout. Runs entirely in the `fclk` domain.

## Interface
Parameters:
- `NSRC`, 4: number of sources, legal range 1..4; source 0 has the highest priority.
- `TIMEOUT`, 640: `fclk` cycles spent in WAIT before the request is abandoned and retried.
- `HOLDOFF`, 300: `fclk` cycles in HOLD before the next `int_start`. Must exceed the INT pulse length (32 zclk) plus synchroniser delay, expressed in `fclk`.
- `CNT_W`, 10: width of the shared timer; must hold max(TIMEOUT, HOLDOFF).

Ports (one clock; reset is synchronous and active-high):
- `fclk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `req`  in  NSRC  per-source request strobes, one cycle high each.
- `intack`  in  1  one-cycle INTACK strobe, already synchronised to `fclk`.
- `cfg_wr`  in  1  configuration write strobe.
- `cfg_addr`  in  2  configuration register select.
- `cfg_din`  in  8  configuration write data.
- `int_start`  out  1  one-cycle start strobe to the INT generator.
- `vector`  out  8  IM2 vector for the current/last selected source.
- `served`  out  NSRC  one-hot strobe marking the source retired on INTACK.
- `pending`  out  NSRC  pending register, for status readback.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
Registers:
- `pend[NSRC]`, `en[NSRC]`, `vbase[4:0]`, `sel[1:0]`, state, timer.

Config writes (effective on the edge where `cfg_wr` is high):
- Address 0: `en` <= `cfg_din[NSRC-1:0]`.
- Address 1: `vbase` <= `cfg_din[7:3]`.
- Address 2: write-1-to-clear `pend`.
- Address 3: write-1-to-set `pend`.

Pending update per bit, in priority order:
- set (`req`, or address-3 write) wins over clear (address-2 write, or INTACK retire).
- A source masked by `en` still latches pending; it is simply not eligible for selection.

Vector: `vector = {vbase, sel, 1'b0}`. It always reflects the registers and is stable from `int_start` until the next selection.

State machine:
- IDLE: if `pend & en` is nonzero, capture the lowest set index into `sel`, pulse `int_start`, load timer with TIMEOUT-1, go to WAIT. Otherwise stay in IDLE.
- WAIT: on `intack`, clear `pend[sel]` (subject to the set-wins rule), pulse `served[sel]`, load timer with HOLDOFF-1, go to HOLD. Else, when timer reaches 0, load timer with HOLDOFF-1 and go to HOLD; `pend` is untouched, so the source is retried. Else decrement the timer.
- HOLD: decrement the timer; when it reaches 0, go to IDLE. `intack` is ignored here.
- `intack` outside WAIT is ignored: no pend change and no `served` pulse.
- Clearing `en` or `pend` of `sel` during WAIT does not abort. A later INTACK still pulses `served[sel]`, and clearing an already-clear bit is harmless.
- Bits at or above NSRC in `cfg_din` are ignored.

Reset values:
- Registers: `pend`=0, `en`=0, `vbase`=5'b11111, `sel`=0, state IDLE, timer 0.
- Outputs: `int_start`=0, `served`=0, `busy`=0, `vector`=8'hF8.

## Timing
- `req[i]` high in cycle t sets `pend[i]` at the edge ending t; `pending` is visible in t+1.
- From IDLE with `en[i]`=1, `int_start` is high in cycle t+2, and WAIT and `busy` begin in the same cycle. Both `int_start` and `served` are registered.
- `intack` sampled in WAIT is accepted, including the cycle `int_start` is high. The retire and `served` take effect the following cycle.
- Timeout: with no INTACK, WAIT lasts exactly TIMEOUT cycles.
- HOLD lasts exactly HOLDOFF cycles.
- Minimum spacing between consecutive `int_start` pulses is therefore HOLDOFF+2 cycles: 1 WAIT cycle, then HOLDOFF cycles of HOLD, then 1 IDLE cycle.
- Priority is re-evaluated only in IDLE. A higher-priority request arriving during WAIT or HOLD waits its turn.
- `rst` high at any edge forces the reset values on that edge, including mid-WAIT or mid-HOLD; no `int_start` or `served` is issued afterwards.

## Test plan
- Reset, write `en`=4'b0001, pulse `req[0]` at t -> `int_start` at t+2, `vector`=8'hF8. `intack` at t+5 -> `served`=4'b0001 at t+6, `pend[0]`=0, `busy` drops after 300 HOLD cycles.
- Pulse `req[2]` and `req[1]` together with all enabled -> first `int_start` with `vector`=8'hFA. After ack and HOLDOFF, second `int_start` with `vector`=8'hFC, spacing ≥ HOLDOFF+2.
- No `intack` -> WAIT lasts 640 cycles, `pend` is kept, `int_start` repeats every 640+300+1 cycles until acked.
- `req[3]` with `en[3]`=0 -> `pending[3]`=1 and no `int_start`. Set `en[3]` -> `int_start` two cycles later. Write `vbase`=8'h80 -> `vector`=8'h86.
- `req[0]` in the same cycle as the retiring `intack` for sel 0 -> `pend[0]` stays 1 and is re-served after HOLD. An address-2 clear together with `req` leaves the bit set.
- Assert `rst` in mid-WAIT, then `intack` -> no `served`, all outputs return to reset values.
